// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU control decoder and the execute stage.
// Holds the 4-bit ALU control codes, default datapath widths and the
// execute-stage occupancy state encoding.
package alu_pkg;

  // Default widths for the execute datapath
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  // ALU control codes produced by alu_control
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Occupancy of the MAIN/SKID pair in the execute stage
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,   // MAIN invalid, SKID invalid
    ST_BUSY  = 2'd1,   // MAIN valid,   SKID invalid
    ST_FULL  = 2'd2    // MAIN valid,   SKID valid
  } stage_state_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: decode-side and write-back-side handshake bundle for the
// execute stage.
//   in_*  : operation from decode (in_valid/in_ready handshake)
//   out_* : registered result toward memory/write-back (out_valid/out_ready)
// Modports:
//   master : the upstream/downstream environment (drives in_* and out_ready)
//   slave  : the execute stage itself
interface alu_exec_stage_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_alu_ctrl;
  logic [DATA_W-1:0] in_op_a;
  logic [DATA_W-1:0] in_op_b;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;
  logic              out_illegal;

  modport master (
    output in_valid, in_alu_ctrl, in_op_a, in_op_b, in_rd, in_reg_write,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_zero, out_rd, out_reg_write, out_illegal
  );

  modport slave (
    input  in_valid, in_alu_ctrl, in_op_a, in_op_b, in_rd, in_reg_write,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_zero, out_rd, out_reg_write, out_illegal
  );

endinterface

// File: rtl/alu_exec_stage_core.sv
// alu_core: purely combinational ALU for the execute stage.
//   ctrl    in  4       ALU control code (AND/OR/ADD/SUB)
//   a, b    in  DATA_W  operands
//   result  out DATA_W  ALU result (0 for an unknown code)
//   zero    out 1       result == 0
//   illegal out 1       ctrl is not one of the four legal codes
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal
);

  // Operation select; ADD/SUB wrap modulo 2^DATA_W with no carry out
  always_comb begin
    result  = {DATA_W{1'b0}};
    illegal = 1'b0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: begin
        result  = {DATA_W{1'b0}};
        illegal = 1'b1;
      end
    endcase
  end

  // Zero flag feeds beq resolution downstream
  always_comb begin
    zero = (result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage downstream of the ALU control decoder.
// Computes the ALU operation on the incoming path, then stores the finished
// result in a two-entry MAIN/SKID buffer so downstream backpressure never
// reaches in_ready combinationally.
//   clk    in  1   rising-edge clock
//   rst_n  in  1   synchronous active-low reset (highest priority)
//   flush  in  1   synchronous flush; drops both entries and any same-cycle accept
//   bus    slave   in_* decode handshake and out_* write-back handshake
// The interface instance must use the same DATA_W/REG_AW as this module.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_exec_stage_if.slave    bus
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              illegal;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } entry_t;

  stage_state_t      state_r;
  stage_state_t      state_nx_s;
  entry_t            main_r;
  entry_t            skid_r;
  entry_t            in_entry_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              accept_s;
  logic              drain_s;
  logic              ld_main_in_s;
  logic              ld_main_skid_s;
  logic              ld_skid_in_s;
  logic [DATA_W-1:0] core_result_s;
  logic              core_zero_s;
  logic              core_illegal_s;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .ctrl    (bus.in_alu_ctrl),
    .a       (bus.in_op_a),
    .b       (bus.in_op_b),
    .result  (core_result_s),
    .zero    (core_zero_s),
    .illegal (core_illegal_s)
  );

  // Handshake qualifiers; both use only registered ready/valid
  always_comb begin
    accept_s = bus.in_valid & in_ready_r;
    drain_s  = out_valid_r & bus.out_ready;
  end

  // Package the computed op; an illegal code never writes back
  always_comb begin
    in_entry_s.result    = core_result_s;
    in_entry_s.zero      = core_zero_s;
    in_entry_s.illegal   = core_illegal_s;
    in_entry_s.rd        = bus.in_rd;
    in_entry_s.reg_write = bus.in_reg_write & ~core_illegal_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; flush overrides accept and drain
  always_comb begin
    state_nx_s = state_r;
    if (flush) begin
      state_nx_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_nx_s = accept_s ? ST_BUSY : ST_EMPTY;
        ST_BUSY: begin
          if (accept_s && !drain_s) begin
            state_nx_s = ST_FULL;
          end else if (!accept_s && drain_s) begin
            state_nx_s = ST_EMPTY;
          end else begin
            state_nx_s = ST_BUSY;
          end
        end
        ST_FULL:  state_nx_s = drain_s ? ST_BUSY : ST_FULL;
        default:  state_nx_s = ST_EMPTY;
      endcase
    end
  end

  // Entry load controls derived from state and handshakes
  always_comb begin
    ld_main_in_s   = 1'b0;
    ld_main_skid_s = 1'b0;
    ld_skid_in_s   = 1'b0;
    if (flush) begin
      ld_main_in_s   = 1'b0;
      ld_main_skid_s = 1'b0;
      ld_skid_in_s   = 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: ld_main_in_s = accept_s;
        ST_BUSY: begin
          // Accept with drain refills MAIN directly: no bubble
          ld_main_in_s = accept_s & drain_s;
          ld_skid_in_s = accept_s & ~drain_s;
        end
        ST_FULL:  ld_main_skid_s = drain_s;
        default: begin
          ld_main_in_s   = 1'b0;
          ld_main_skid_s = 1'b0;
          ld_skid_in_s   = 1'b0;
        end
      endcase
    end
  end

  // Entry storage and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_r      <= '0;
      skid_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx_s != ST_FULL);
      out_valid_r <= (state_nx_s != ST_EMPTY);
      if (ld_main_in_s) begin
        main_r <= in_entry_s;
      end else if (ld_main_skid_s) begin
        main_r <= skid_r;
      end
      if (ld_skid_in_s) begin
        skid_r <= in_entry_s;
      end
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_result    = main_r.result;
  assign bus.out_zero      = main_r.zero;
  assign bus.out_illegal   = main_r.illegal;
  assign bus.out_rd        = main_r.rd;
  assign bus.out_reg_write = main_r.reg_write;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed, table-driven bench for alu_exec_stage.
module tb_alu_exec_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   failures;

  alu_exec_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  alu_exec_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
    logic        exp_rw;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic rw);
    bus.in_valid     = v;
    bus.in_alu_ctrl  = c;
    bus.in_op_a      = a;
    bus.in_op_b      = b;
    bus.in_rd        = rd;
    bus.in_reg_write = rw;
  endtask

  task automatic check_out(input string name, input logic [31:0] res, input logic [4:0] rd);
    check({name, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({name, ".result"}, bus.out_result, res);
    check({name, ".rd"}, {27'd0, bus.out_rd}, {27'd0, rd});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{4'b0010, 32'h0000_000F, 32'h0000_0005, 5'd1, 1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{4'b0110, 32'h0000_000F, 32'h0000_0005, 5'd2, 1'b1, 32'h0000_000A, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{4'b0000, 32'h0000_000F, 32'h0000_0005, 5'd3, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'b0001, 32'h0000_000F, 32'h0000_0005, 5'd4, 1'b1, 32'h0000_000F, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'b0110, 32'h0000_0007, 32'h0000_0007, 5'd5, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{4'b1111, 32'h1234_5678, 32'h0000_0001, 5'd6, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd7, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{4'b0110, 32'h0000_0000, 32'h0000_0001, 5'd8, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};

    // Reset held two cycles with a valid op offered
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'b0010, 32'd3, 32'd4, 5'd9, 1'b1);
    tick();
    tick();
    check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst.out_result", bus.out_result, 32'd0);
    check("rst.out_zero", {31'd0, bus.out_zero}, 32'd0);
    check("rst.out_illegal", {31'd0, bus.out_illegal}, 32'd0);
    check("rst.out_reg_write", {31'd0, bus.out_reg_write}, 32'd0);
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst.out_valid_after", {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back table: one op per cycle with out_ready held high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].rw);
      tick();
      check($sformatf("vec%0d.valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("vec%0d.result", i), bus.out_result, vecs[i].exp_res);
      check($sformatf("vec%0d.zero", i), {31'd0, bus.out_zero}, {31'd0, vecs[i].exp_zero});
      check($sformatf("vec%0d.illegal", i), {31'd0, bus.out_illegal}, {31'd0, vecs[i].exp_ill});
      check($sformatf("vec%0d.reg_write", i), {31'd0, bus.out_reg_write}, {31'd0, vecs[i].exp_rw});
      check($sformatf("vec%0d.rd", i), {27'd0, bus.out_rd}, {27'd0, vecs[i].rd});
      check($sformatf("vec%0d.in_ready", i), {31'd0, bus.in_ready}, 32'd1);
    end
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    check("b2b.drained", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: two ops fill MAIN/SKID, third waits for in_ready
    bus.out_ready = 1'b0;
    drive(1'b1, 4'b0010, 32'd1, 32'd2, 5'd11, 1'b1);   // A: 3
    tick();
    check_out("bp.A", 32'd3, 5'd11);
    check("bp.ready_busy", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 4'b0001, 32'd8, 32'd1, 5'd12, 1'b1);   // B: 9
    tick();
    check_out("bp.hold1", 32'd3, 5'd11);
    check("bp.ready_full", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b1, 4'b0110, 32'd10, 32'd4, 5'd13, 1'b1);  // C: 6
    tick();
    check_out("bp.hold2", 32'd3, 5'd11);
    check("bp.ready_full2", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check_out("bp.hold3", 32'd3, 5'd11);
    bus.out_ready = 1'b1;
    tick();
    check_out("bp.B", 32'd9, 5'd12);
    check("bp.ready_back", {31'd0, bus.in_ready}, 32'd1);
    tick();
    check_out("bp.C", 32'd6, 5'd13);
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    check("bp.empty", {31'd0, bus.out_valid}, 32'd0);

    // Flush while FULL with a same-cycle offered op
    bus.out_ready = 1'b0;
    drive(1'b1, 4'b0010, 32'd20, 32'd1, 5'd14, 1'b1);
    tick();
    drive(1'b1, 4'b0010, 32'd30, 32'd1, 5'd15, 1'b1);
    tick();
    check("fl.full", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b1, 4'b0010, 32'd40, 32'd1, 5'd16, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl.in_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("fl.no_stale%0d", k), {31'd0, bus.out_valid}, 32'd0);
    end
    drive(1'b1, 4'b0110, 32'd50, 32'd8, 5'd17, 1'b1);   // 42
    tick();
    check_out("fl.recover", 32'd42, 5'd17);
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    check("fl.recover_empty", {31'd0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
